// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from four requesters into a single UART Tx core,
// with per-grant burst limiting and a Tx handshake timeout.
module uart_tx_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  last_i,
  output logic [3:0]  ack_o,
  output logic [3:0]  grant_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        err_o,
  output logic [5:0]  state_o
);

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    ARB       = 6'b000010,
    LOAD      = 6'b000100,
    WAIT_BUSY = 6'b001000,
    WAIT_DONE = 6'b010000,
    RELEASE   = 6'b100000
  } state_t;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
  localparam logic [3:0] TIMEOUT_C   = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  last_winner_q, last_winner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [3:0]  to_cnt_q, to_cnt_d;
  logic        last_r_q, last_r_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic [3:0]  ack_q, ack_d;
  logic        err_q, err_d;

  logic [1:0]  win_idx;
  logic        win_found;
  logic [1:0]  cand;
  logic [7:0]  cur_byte;

  // Search starts just after the previous winner, so the previous winner is tried last.
  always_comb begin
    win_idx   = last_winner_q;
    win_found = 1'b0;
    cand      = last_winner_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_winner_q + 2'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign cur_byte = data_i[{gidx_q, 3'b000} +: 8];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    to_cnt_d      = to_cnt_q;
    last_r_d      = last_r_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    ack_d         = 4'b0000;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_i) state_d = ARB;
      end
      ARB: begin
        if (win_found) begin
          grant_d     = 4'b0001 << win_idx;
          gidx_d      = win_idx;
          burst_cnt_d = 4'd0;
          state_d     = LOAD;
        end else begin
          grant_d = 4'b0000;
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (req_i[gidx_q]) begin
          tx_data_d  = cur_byte;
          last_r_d   = last_i[gidx_q];
          if (burst_cnt_q < MAX_BURST_C) burst_cnt_d = burst_cnt_q + 4'd1;
          tx_start_d = 1'b1;
          ack_d      = grant_q;
          to_cnt_d   = 4'd0;
          state_d    = WAIT_BUSY;
        end else begin
          state_d = RELEASE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else begin
          if (to_cnt_q < TIMEOUT_C) to_cnt_d = to_cnt_q + 4'd1;
          if (to_cnt_d == TIMEOUT_C) begin
            err_d   = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (last_r_q || (burst_cnt_q == MAX_BURST_C) || !req_i[gidx_q])
            state_d = RELEASE;
          else
            state_d = LOAD;
        end
      end
      RELEASE: begin
        last_winner_d = gidx_q;
        grant_d       = 4'b0000;
        state_d       = (|req_i) ? ARB : IDLE;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      gidx_q        <= 2'd0;
      last_winner_q <= 2'd3;
      burst_cnt_q   <= 4'd0;
      to_cnt_q      <= 4'd0;
      last_r_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      ack_q         <= 4'b0000;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      last_r_q      <= last_r_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
    end
  end

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for a single transfer, then directed
// sequences for bursts, round-robin, timeout, async reset and early request drop.
module tb_uart_tx_arbiter;

  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_ARB  = 6'b000010;
  localparam logic [5:0] S_LOAD = 6'b000100;
  localparam logic [5:0] S_WB   = 6'b001000;
  localparam logic [5:0] S_WD   = 6'b010000;
  localparam logic [5:0] S_REL  = 6'b100000;

  logic        clk;
  logic        rst;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  last_i;
  logic [3:0]  ack_o;
  logic [3:0]  grant_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy_i;
  logic        err_o;
  logic [5:0]  state_o;

  uart_tx_arbiter #(.MAX_BURST(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .last_i     (last_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .tx_busy_i  (tx_busy_i),
    .err_o      (err_o),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       busy;
    logic [5:0] st;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       start;
    logic       err;
    logic [7:0] txd;
  } vec_t;

  vec_t vecs [16];

  int n_checks = 0;
  int n_fail   = 0;

  logic       model_on;
  int         busy_left;
  logic       mon_on;
  int         grant_log [$];
  int         burst_log [$];
  int         exp_order [$];
  logic [3:0] prev_grant;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] last, input logic busy,
                              input logic [5:0] st, input logic [3:0] grant, input logic [3:0] ack,
                              input logic start, input logic err, input logic [7:0] txd);
    vec_t v;
    v.req = req; v.last = last; v.busy = busy; v.st = st; v.grant = grant;
    v.ack = ack; v.start = start; v.err = err; v.txd = txd;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    req_i     = v.req;
    last_i    = v.last;
    tx_busy_i = v.busy;
    data_i    = 32'h0000_00A5;
  endtask

  // One clock: outputs settle 1 ns after the edge, then the Tx model and the grant monitor react.
  task automatic step();
    int idx;
    @(posedge clk);
    #1;
    if (mon_on) begin
      if (grant_o != 4'b0000 && prev_grant == 4'b0000) begin
        grant_log.push_back(onehot_idx(grant_o));
        burst_log.push_back(0);
      end
      if (ack_o != 4'b0000 && grant_log.size() > 0) begin
        burst_log[burst_log.size()-1]++;
        if (grant_log.size() <= exp_order.size()) begin
          idx = exp_order[grant_log.size()-1];
          check_output("burst_ack", 32'(ack_o), 32'(4'b0001 << idx));
          check_output("burst_txdata", 32'(tx_data_o), 32'(8'h10 + idx));
        end
      end
      prev_grant = grant_o;
    end
    if (model_on) begin
      if (tx_start_o) begin
        tx_busy_i = 1'b1;
        busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy_i = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_i     = 4'b0000;
    last_i    = 4'b0000;
    tx_busy_i = 1'b0;
    data_i    = 32'h0;
    model_on  = 1'b0;
    busy_left = 0;
    mon_on    = 1'b0;
    prev_grant = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic run_burst(input string name, input logic [3:0] req, input int ngrants);
    int cyc;
    do_reset();
    grant_log.delete();
    burst_log.delete();
    mon_on    = 1'b1;
    model_on  = 1'b1;
    data_i    = 32'h1312_1110;
    last_i    = 4'b0000;
    req_i     = req;
    cyc = 0;
    while (grant_log.size() <= ngrants && cyc < 800) begin
      step();
      cyc++;
    end
    check_output({name, "_done_in_budget"}, 32'(grant_log.size() > ngrants), 32'd1);
    for (int i = 0; i < ngrants; i++) begin
      if (i < grant_log.size()) begin
        check_output($sformatf("%s_grant%0d", name, i), 32'(grant_log[i]), 32'(exp_order[i]));
        check_output($sformatf("%s_bytes%0d", name, i), 32'(burst_log[i]), 32'd4);
      end
    end
  endtask

  initial begin
    int cyc;
    int n;
    int extra_acks;
    logic saw_release;

    // Single transfer, cycle by cycle; busy held for 10 cycles.
    vecs[0]  = mk(4'b0001, 4'b0001, 1'b0, S_ARB,  4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
    vecs[1]  = mk(4'b0001, 4'b0001, 1'b0, S_LOAD, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'h00);
    vecs[2]  = mk(4'b0001, 4'b0001, 1'b0, S_WB,   4'b0001, 4'b0001, 1'b1, 1'b0, 8'hA5);
    for (int i = 3; i <= 12; i++)
      vecs[i] = mk(4'b0000, 4'b0000, 1'b1, S_WD,  4'b0001, 4'b0000, 1'b0, 1'b0, 8'hA5);
    vecs[13] = mk(4'b0000, 4'b0000, 1'b0, S_REL,  4'b0001, 4'b0000, 1'b0, 1'b0, 8'hA5);
    vecs[14] = mk(4'b0000, 4'b0000, 1'b0, S_IDLE, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5);
    vecs[15] = mk(4'b0000, 4'b0000, 1'b0, S_IDLE, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5);

    rst = 1'b0;
    model_on = 1'b0;
    mon_on = 1'b0;
    busy_left = 0;
    prev_grant = 4'b0000;
    req_i = 4'b0000; last_i = 4'b0000; tx_busy_i = 1'b0; data_i = 32'h0;
    #12;
    check_output("reset_state", 32'(state_o), 32'(S_IDLE));
    check_output("reset_grant", 32'(grant_o), 32'd0);
    check_output("reset_txdata", 32'(tx_data_o), 32'd0);
    check_output("reset_strobes", 32'({ack_o, tx_start_o, err_o}), 32'd0);

    $display("[TB] single request table");
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_output($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      check_output($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vecs[i].grant));
      check_output($sformatf("v%0d_ack", i), 32'(ack_o), 32'(vecs[i].ack));
      check_output($sformatf("v%0d_start", i), 32'(tx_start_o), 32'(vecs[i].start));
      check_output($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
      check_output($sformatf("v%0d_txdata", i), 32'(tx_data_o), 32'(vecs[i].txd));
    end

    $display("[TB] four requesters, full bursts");
    exp_order = '{0, 1, 2, 3, 0};
    run_burst("rr4", 4'b1111, 5);

    $display("[TB] requesters 0 and 2");
    exp_order = '{0, 2, 0, 2};
    run_burst("rr02", 4'b0101, 4);

    $display("[TB] handshake timeout");
    do_reset();
    data_i = 32'h0000_00A5; last_i = 4'b0001; req_i = 4'b0001;
    cyc = 0;
    while (!tx_start_o && cyc < 10) begin step(); cyc++; end
    check_output("to_start_seen", 32'(tx_start_o), 32'd1);
    n = 0;
    while (!err_o && n < 30) begin step(); n++; end
    check_output("to_latency", 32'(n), 32'd15);
    check_output("to_state_release", 32'(state_o), 32'(S_REL));
    step();
    check_output("to_err_one_cycle", 32'(err_o), 32'd0);
    check_output("to_next_arb", 32'(state_o), 32'(S_ARB));

    $display("[TB] async reset in WAIT_DONE");
    do_reset();
    model_on = 1'b1;
    data_i = 32'h0000_00A5; last_i = 4'b0000; req_i = 4'b0001;
    cyc = 0;
    while (state_o != S_WD && cyc < 10) begin step(); cyc++; end
    check_output("rst_reached_wd", 32'(state_o), 32'(S_WD));
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_async_state", 32'(state_o), 32'(S_IDLE));
    check_output("rst_async_grant", 32'(grant_o), 32'd0);
    check_output("rst_async_txdata", 32'(tx_data_o), 32'd0);
    check_output("rst_async_strobes", 32'({ack_o, tx_start_o, err_o}), 32'd0);
    tx_busy_i = 1'b0; busy_left = 0;
    req_i = 4'b0010;
    repeat (2) begin
      step();
      check_output("rst_held_strobes", 32'({ack_o, tx_start_o}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    while (grant_o == 4'b0000 && cyc < 10) begin step(); cyc++; end
    check_output("rst_first_grant", 32'(grant_o), 32'(4'b0010));

    $display("[TB] request dropped during WAIT_DONE");
    do_reset();
    model_on = 1'b1;
    data_i = 32'h0000_00A5; last_i = 4'b0000; req_i = 4'b0001;
    cyc = 0;
    while (ack_o == 4'b0000 && cyc < 10) begin step(); cyc++; end
    check_output("drop_first_ack", 32'(ack_o), 32'(4'b0001));
    step();
    check_output("drop_in_wd", 32'(state_o), 32'(S_WD));
    req_i = 4'b0000;
    extra_acks = 0;
    saw_release = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack_o != 4'b0000) extra_acks++;
      if (state_o == S_REL) saw_release = 1'b1;
    end
    check_output("drop_no_extra_ack", 32'(extra_acks), 32'd0);
    check_output("drop_saw_release", 32'(saw_release), 32'd1);
    check_output("drop_final_idle", 32'(state_o), 32'(S_IDLE));
    check_output("drop_grant_cleared", 32'(grant_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum bytes sent per grant before arbitration rotates (range 1..15).
REQ-002 Parameter TIMEOUT, default 15: maximum cycles in WAIT_BUSY before abort (range 1..15).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  4  per-requester byte-available flags; bit n belongs to requester n.
REQ-006 data_i  input  32  packed bytes; requester n byte is data_i[8n+7:8n].
REQ-007 last_i  input  4  per-requester end-of-message flag, qualified with the byte.
REQ-008 ack_o  output  4  one-cycle pulse: the granted requester's byte was taken.
REQ-009 grant_o  output  4  one-hot current grant; all zero when no requester is granted.
REQ-010 tx_data_o  output  8  byte presented to the Tx core.
REQ-011 tx_start_o  output  1  one-cycle start strobe to the Tx core.
REQ-012 tx_busy_i  input  1  Tx core busy; high while a frame is on the wire.
REQ-013 err_o  output  1  one-cycle pulse on a Tx handshake timeout.
REQ-014 state_o  output  6  one-hot state, for debug.

Function
REQ-015 The state machine SHALL use one-hot encoding: IDLE=000001, ARB=000010, LOAD=000100, WAIT_BUSY=001000, WAIT_DONE=010000, RELEASE=100000.
REQ-016 Any non-legal state value SHALL return to IDLE on the next clock, with grant_o cleared.
REQ-017 IDLE: if any req_i bit is high, go to ARB; otherwise stay in IDLE.
REQ-018 ARB (1 cycle): pick the winner by round-robin, searching from (last_winner+1) mod 4 upward with wrap.
REQ-019 ARB: register the winner into grant_o, clear burst_cnt, go to LOAD.
REQ-020 ARB: if req_i is all zero in this cycle, go to IDLE with no grant.
REQ-021 LOAD (1 cycle), if req_i[g] is low: go to RELEASE with no strobe.
REQ-022 LOAD, if req_i[g] is high:
- latch the granted byte into tx_data_o and last_i[g] into last_r;
- increment burst_cnt;
- pulse tx_start_o and ack_o[g] for exactly this one cycle;
- go to WAIT_BUSY.
REQ-023 tx_start_o and ack_o SHALL be decoded from the registered state (Moore outputs); ack_o bits other than g SHALL stay 0.
REQ-024 tx_data_o SHALL hold its value from LOAD until the next LOAD.
REQ-025 WAIT_BUSY: clear to_cnt on entry; when tx_busy_i=1, go to WAIT_DONE.
REQ-026 WAIT_BUSY: else increment to_cnt; when to_cnt reaches TIMEOUT, pulse err_o for one cycle and go to RELEASE.
REQ-027 WAIT_DONE: wait for tx_busy_i=0, then:
- go to RELEASE if last_r=1, or burst_cnt=MAX_BURST, or req_i[g]=0;
- otherwise go to LOAD.
REQ-028 RELEASE (1 cycle): last_winner<=g and grant_o<=0.
REQ-029 RELEASE exit: go to ARB if any req_i bit is high, else go to IDLE.
REQ-030 Latency: with req_i first sampled high in IDLE at edge k, tx_start_o SHALL be high during the cycle following edge k+2.
REQ-031 A simultaneous request from the current holder and others during RELEASE SHALL NOT re-grant the holder while any other requester is pending.
REQ-032 burst_cnt SHALL be 4 bits and SHALL never exceed MAX_BURST; to_cnt SHALL be 4 bits and saturate at TIMEOUT.

Reset
REQ-033 On rst low, immediately and regardless of clk: state=IDLE, grant_o=0, ack_o=0, tx_start_o=0, err_o=0, tx_data_o=8'h00, burst_cnt=0, to_cnt=0, last_r=0.
REQ-034 On reset, last_winner=3, so requester 0 has first priority.
REQ-035 Reset asserted mid-transfer SHALL abort without any further tx_start_o or ack_o pulse after release.

Verification
REQ-036 Single request: req_i=0001, data_i[7:0]=8'hA5, last_i=0001, Tx busy for 10 cycles -> one tx_start_o, tx_data_o=A5, ack_o=0001, grant released, IDLE.
REQ-037 All four request continuously with last_i=0 -> grants in order 0,1,2,3,0, each grant carrying exactly MAX_BURST=4 bytes.
REQ-038 req_i=0101 held -> grant order 0,2,0,2; requester 0 is never granted twice in succession.
REQ-039 tx_busy_i held 0 after tx_start_o -> err_o pulses exactly TIMEOUT=15 cycles into WAIT_BUSY, then RELEASE, then next arbitration.
REQ-040 rst pulled low while in WAIT_DONE -> all outputs at reset values immediately; after rst is released with req_i=0010, requester 1 is granted first.
REQ-041 req_i[g] drops during WAIT_DONE -> RELEASE after busy falls, with no extra ack_o.
